// File: rtl/seg7_frame_decoder.sv
// seg7_frame_decoder: turns active-low 7-segment digit patterns back into a BCD word and its binary value.
// Optional macro SEG7_BLANK_EN lets leading all-off digits decode as 0.
module seg7_frame_decoder #(
    parameter int NUM_DIGITS = 4,
    parameter int BIN_W      = 14
) (
    input  logic                    CLOCK_50,
    input  logic                    resetn,
    input  logic [6:0]              seg_in,
    input  logic                    seg_strobe,
    input  logic                    sof,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [BIN_W-1:0]        bin_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    err,
    output logic                    overrun
);

    localparam int W  = 4 * NUM_DIGITS;
    localparam int CW = $clog2(NUM_DIGITS + 1);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        HOLD
    } state_t;

    state_t             state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [BIN_W-1:0]   acc, acc_n;
    logic [W-1:0]       sr, sr_n;
    logic               errf, errf_n;
    logic               ovr_n;
    logic               load;
    logic               start, shift;
    logic               take_first, take_next;
    logic [3:0]         dig;
    logic               dok;
    logic [3:0]         nib;
    logic [BIN_W-1:0]   dval;
    logic               blank_hit;

    assign start = seg_strobe & sof;
    assign shift = seg_strobe & ~sof;

`ifdef SEG7_BLANK_EN
    logic blank, blank_n;
    // a blank only counts as a leading zero while the frame has been blank so far
    assign blank_hit = (seg_in == 7'h7F) && (start || blank);
`else
    assign blank_hit = 1'b0;
`endif

    // segment pattern to digit lookup
    always_comb begin
        dig = 4'd0;
        dok = 1'b1;
        if (!blank_hit) begin
            case (seg_in)
                7'b1000000: dig = 4'd0;
                7'b1111001: dig = 4'd1;
                7'b0100100: dig = 4'd2;
                7'b0110000: dig = 4'd3;
                7'b0011001: dig = 4'd4;
                7'b0010010: dig = 4'd5;
                7'b0000010: dig = 4'd6;
                7'b1111000: dig = 4'd7;
                7'b0000000: dig = 4'd8;
                7'b0011000: dig = 4'd9;
                default:    dok = 1'b0;
            endcase
        end
    end

    assign nib  = dok ? dig : 4'hF;
    assign dval = dok ? BIN_W'(dig) : '0;

    // next state, frame accumulation and hold-entry detection
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        acc_n      = acc;
        sr_n       = sr;
        errf_n     = errf;
        ovr_n      = overrun;
        take_first = 1'b0;
        take_next  = 1'b0;
        load       = 1'b0;
`ifdef SEG7_BLANK_EN
        blank_n    = blank;
`endif
        case (state)
            IDLE: begin
                take_first = start;
            end
            CAPTURE: begin
                take_first = start;
                take_next  = shift;
            end
            HOLD: begin
                if (out_ready) begin
                    state_n    = IDLE;
                    take_first = start;
                end
                if (seg_strobe && !(out_ready && sof))
                    ovr_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase

        if (take_first) begin
            acc_n   = dval;
            sr_n    = W'(nib);
            cnt_n   = CW'(1);
            errf_n  = ~dok;
            state_n = (NUM_DIGITS == 1) ? HOLD : CAPTURE;
`ifdef SEG7_BLANK_EN
            blank_n = blank_hit;
`endif
        end else if (take_next) begin
            acc_n  = (acc << 3) + (acc << 1) + dval;
            sr_n   = W'({sr, nib});
            cnt_n  = cnt + 1'b1;
            errf_n = errf | ~dok;
            if (cnt_n == CW'(NUM_DIGITS))
                state_n = HOLD;
`ifdef SEG7_BLANK_EN
            blank_n = blank_hit;
`endif
        end

        load = (state_n == HOLD) && (take_first || take_next);
    end

    // state registers; result outputs change only when a frame completes
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            sr      <= '0;
            errf    <= 1'b0;
            overrun <= 1'b0;
            bcd_out <= '0;
            bin_out <= '0;
            err     <= 1'b0;
`ifdef SEG7_BLANK_EN
            blank   <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            acc     <= acc_n;
            sr      <= sr_n;
            errf    <= errf_n;
            overrun <= ovr_n;
`ifdef SEG7_BLANK_EN
            blank   <= blank_n;
`endif
            if (load) begin
                bcd_out <= sr_n;
                bin_out <= errf_n ? '0 : acc_n;
                err     <= errf_n;
            end
        end
    end

    assign out_valid = (state == HOLD);

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// tb_seg7_frame_decoder: directed frames checked against a frame-level
// model every cycle, plus literal checks on key results.
module tb_seg7_frame_decoder;

    localparam int N     = 4;
    localparam int BIN_W = 14;

    logic              CLOCK_50 = 1'b0;
    logic              resetn;
    logic [6:0]        seg_in;
    logic              seg_strobe;
    logic              sof;
    logic [4*N-1:0]    bcd_out;
    logic [BIN_W-1:0]  bin_out;
    logic              out_valid;
    logic              out_ready;
    logic              err;
    logic              overrun;

    seg7_frame_decoder #(.NUM_DIGITS(N), .BIN_W(BIN_W)) dut (
        .CLOCK_50  (CLOCK_50),
        .resetn    (resetn),
        .seg_in    (seg_in),
        .seg_strobe(seg_strobe),
        .sof       (sof),
        .bcd_out   (bcd_out),
        .bin_out   (bin_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err),
        .overrun   (overrun)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    logic [6:0] pats [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000
    };
    localparam logic [6:0] BAD   = 7'b1010101;
    localparam logic [6:0] BLANK = 7'b1111111;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // returns -1 for a pattern that is not a digit
    function automatic int dec(input logic [6:0] p, input bit lead);
        for (int k = 0; k < 10; k++)
            if (pats[k] == p) return k;
`ifdef SEG7_BLANK_EN
        if (p == BLANK && lead) return 0;
`endif
        return -1;
    endfunction

    logic [6:0]       frame[$];
    bit               m_valid;
    logic [4*N-1:0]   m_bcd;
    logic [BIN_W-1:0] m_bin;
    bit               m_err;
    bit               m_ovr;
    bit               m_acc;
    bit               m_lead;
    int               m_d;
    int               m_sum;
    int               m_pw;

    // frame-level reference: collect patterns, evaluate a whole frame at once
    always @(posedge CLOCK_50) begin
        if (!resetn) begin
            frame.delete();
            m_valid = 0;
            m_bcd   = '0;
            m_bin   = '0;
            m_err   = 0;
            m_ovr   = 0;
        end else begin
            m_acc = m_valid && out_ready;
            if (m_valid && seg_strobe && !(m_acc && sof)) m_ovr = 1;
            if (m_acc) m_valid = 0;
            if (!m_valid && seg_strobe) begin
                if (sof) begin
                    frame.delete();
                    frame.push_back(seg_in);
                end else if (frame.size() > 0) begin
                    frame.push_back(seg_in);
                end
            end
            if (frame.size() == N) begin
                m_lead = 1;
                m_err  = 0;
                m_sum  = 0;
                m_bcd  = '0;
                m_pw   = 1;
                for (int i = N - 1; i >= 0; i--) begin
                    m_lead = 1;
                    for (int j = 0; j < i; j++)
                        if (frame[j] != BLANK) m_lead = 0;
                    m_d = dec(frame[i], m_lead);
                    if (m_d < 0) begin
                        m_err = 1;
                        m_bcd[4*(N-1-i) +: 4] = 4'hF;
                    end else begin
                        m_bcd[4*(N-1-i) +: 4] = 4'(m_d);
                        m_sum += m_d * m_pw;
                    end
                    m_pw *= 10;
                end
                m_bin   = m_err ? '0 : BIN_W'(m_sum);
                m_valid = 1;
                frame.delete();
            end
        end
    end

    // cycle-by-cycle comparison against the model
    always @(negedge CLOCK_50) begin
        if (chk_en) begin
            check("out_valid", 32'(out_valid), 32'(m_valid));
            check("bcd_out",   32'(bcd_out),   32'(m_bcd));
            check("bin_out",   32'(bin_out),   32'(m_bin));
            check("err",       32'(err),       32'(m_err));
            check("overrun",   32'(overrun),   32'(m_ovr));
        end
    end

    task automatic cyc(input logic st, input logic sf, input logic [6:0] sg,
                       input logic rdy);
        seg_strobe = st;
        sof        = sf;
        seg_in     = sg;
        out_ready  = rdy;
        @(posedge CLOCK_50);
        #2;
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 7'h00, rdy);
    endtask

    task automatic frame4(input logic [6:0] a, input logic [6:0] b,
                          input logic [6:0] c, input logic [6:0] d,
                          input logic rdy);
        cyc(1'b1, 1'b1, a, rdy);
        cyc(1'b1, 1'b0, b, rdy);
        cyc(1'b1, 1'b0, c, rdy);
        cyc(1'b1, 1'b0, d, rdy);
    endtask

    initial begin
        resetn = 1'b0;
        idle(1'b0, 2);
        chk_en = 1'b1;
        check("rst_valid",   32'(out_valid), 32'd0);
        check("rst_bcd",     32'(bcd_out),   32'd0);
        check("rst_bin",     32'(bin_out),   32'd0);
        check("rst_err",     32'(err),       32'd0);
        check("rst_overrun", 32'(overrun),   32'd0);
        resetn = 1'b1;
        idle(1'b1, 1);

        // 2345, one cycle latency, drop after acceptance
        frame4(pats[2], pats[3], pats[4], pats[5], 1'b1);
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_bcd",   32'(bcd_out),   32'h2345);
        check("t1_bin",   32'(bin_out),   32'd2345);
        check("t1_err",   32'(err),       32'd0);
        idle(1'b1, 1);
        check("t1_drop",  32'(out_valid), 32'd0);
        check("t1_keep",  32'(bcd_out),   32'h2345);

        // accept and restart in the same cycle
        frame4(pats[1], pats[2], pats[3], pats[4], 1'b0);
        cyc(1'b1, 1'b1, pats[5], 1'b1);
        cyc(1'b1, 1'b0, pats[6], 1'b1);
        cyc(1'b1, 1'b0, pats[7], 1'b1);
        cyc(1'b1, 1'b0, pats[8], 1'b1);
        check("t2_bcd", 32'(bcd_out), 32'h5678);
        check("t2_bin", 32'(bin_out), 32'd5678);
        check("t2_ovr", 32'(overrun), 32'd0);
        idle(1'b1, 1);

        // 9999 held under backpressure, overrun from strobe in hold
        frame4(pats[9], pats[9], pats[9], pats[9], 1'b0);
        idle(1'b0, 2);
        cyc(1'b1, 1'b0, pats[1], 1'b0);
        idle(1'b0, 2);
        check("t3_valid", 32'(out_valid), 32'd1);
        check("t3_bcd",   32'(bcd_out),   32'h9999);
        check("t3_bin",   32'(bin_out),   32'd9999);
        check("t3_ovr",   32'(overrun),   32'd1);
        idle(1'b1, 2);
        check("t3_ovr_sticky", 32'(overrun), 32'd1);

        // invalid third digit
        frame4(pats[1], pats[2], BAD, pats[4], 1'b1);
        check("t4_bcd", 32'(bcd_out), 32'h12F4);
        check("t4_err", 32'(err),     32'd1);
        check("t4_bin", 32'(bin_out), 32'd0);
        idle(1'b1, 1);

        // partial frame dropped by a new sof
        cyc(1'b1, 1'b1, pats[1], 1'b1);
        cyc(1'b1, 1'b0, pats[2], 1'b1);
        frame4(pats[7], pats[8], pats[9], pats[0], 1'b1);
        check("t5_bcd", 32'(bcd_out), 32'h7890);
        check("t5_bin", 32'(bin_out), 32'd7890);
        check("t5_err", 32'(err),     32'd0);
        idle(1'b1, 1);

        // reset mid-frame
        cyc(1'b1, 1'b1, pats[1], 1'b1);
        cyc(1'b1, 1'b0, pats[2], 1'b1);
        resetn = 1'b0;
        idle(1'b1, 1);
        check("t6_rst_ovr", 32'(overrun), 32'd0);
        check("t6_rst_bcd", 32'(bcd_out), 32'd0);
        resetn = 1'b1;
        cyc(1'b1, 1'b0, pats[3], 1'b1);
        frame4(pats[5], pats[0], pats[0], pats[6], 1'b1);
        check("t6_bcd", 32'(bcd_out), 32'h5006);
        check("t6_bin", 32'(bin_out), 32'd5006);
        idle(1'b1, 1);

        // leading blanks
        frame4(BLANK, BLANK, pats[1], pats[0], 1'b1);
`ifdef SEG7_BLANK_EN
        check("t7_bcd", 32'(bcd_out), 32'h0010);
        check("t7_bin", 32'(bin_out), 32'd10);
        check("t7_err", 32'(err),     32'd0);
`else
        check("t7_bcd", 32'(bcd_out), 32'hFF10);
        check("t7_bin", 32'(bin_out), 32'd0);
        check("t7_err", 32'(err),     32'd1);
`endif
        idle(1'b1, 1);

        // blank after a real digit is never a leading blank
        frame4(BLANK, pats[3], BLANK, pats[2], 1'b1);
        check("t8_err", 32'(err), 32'd1);
        check("t8_bin", 32'(bin_out), 32'd0);
        idle(1'b1, 2);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg7_frame_decoder.md
Name: seg7_frame_decoder

Overview:
- Receiver end of the team's 7-segment display path: accepts active-low segment patterns one digit per strobe, most-significant digit first.
- Decodes each pattern back to a BCD digit and assembles NUM_DIGITS digits into a BCD word.
- Builds the binary value on the fly (acc = acc*10 + digit) and presents the result with a valid/ready handshake.
- Sits between a segment-bus sniffer/scanner and downstream arithmetic or check logic.

Parameters:
- NUM_DIGITS, 4, digits per frame (1..5).
- BIN_W, 14, binary result width; must hold 10^NUM_DIGITS - 1.

Ports:
- CLOCK_50  input  1  system clock, all logic on rising edge.
- resetn  input  1  synchronous, active-low reset.
- seg_in  input  7  segment pattern, active-low; bit0=a, 1=b, 2=c, 3=d, 4=e, 5=f, 6=g.
- seg_strobe  input  1  seg_in valid this cycle.
- sof  input  1  qualifies seg_strobe; marks the first (most-significant) digit of a frame.
- bcd_out  output  4*NUM_DIGITS  assembled BCD word, MS digit in top nibble.
- bin_out  output  BIN_W  binary value of the frame.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- err  output  1  frame contained an undecodable pattern; valid with out_valid.
- overrun  output  1  sticky; a strobe arrived while a result was held.

Behaviour:
- Reset (resetn=0 at a clock edge): state IDLE; bcd_out=0, bin_out=0, out_valid=0, err=0, overrun=0, digit counter=0, accumulator=0. Reset mid-frame or mid-hold discards everything.
- Decode table (seg_in -> digit):
  - 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4
  - 0010010->5, 0000010->6 (6 has top segment), 1111000->7 (7 has no f), 0000000->8, 0011000->9 (9 has no bottom segment)
  - Any other pattern is invalid: nibble stored as 4'hF, internal error flag set.
- States:
  - IDLE: seg_strobe without sof is ignored. seg_strobe&sof loads digit 0: acc=digit (0 if invalid), count=1, error flag from decode. Goes to HOLD if NUM_DIGITS=1, else CAPTURE.
  - CAPTURE: seg_strobe&~sof shifts the decoded nibble into the BCD shift register and sets acc=acc*10+digit (invalid contributes 0; error flag ORed). count increments. On the NUM_DIGITS-th digit, go to HOLD.
  - CAPTURE with seg_strobe&sof: frame restarts as in IDLE; partial frame dropped, no output, overrun unaffected.
  - HOLD: out_valid=1. bcd_out, bin_out and err are registered and stable. If err=1, bin_out=0.
  - HOLD exit: on out_valid&out_ready, go to IDLE and clear out_valid the next cycle. Any seg_strobe in HOLD is dropped and sets overrun.
  - HOLD with out_ready and seg_strobe&sof in the same cycle: the result is accepted and the new frame starts (loads digit 0) that cycle; overrun is not set.
- Timing: latency from the last digit strobe to out_valid is 1 cycle. Back-to-back strobes are supported at one digit per clock.
- Arithmetic: acc is BIN_W wide; the *10 is implemented as (acc<<3)+(acc<<1). Overflow is impossible within the parameter constraint.
- overrun clears only on reset.
- Outputs are updated only on the HOLD entry edge; they hold their previous values during IDLE/CAPTURE.

Optional Feature:
- Macro SEG7_BLANK_EN.
- Defined: all-off pattern 7'b1111111 decodes as digit 0 without setting the error flag, but only while every earlier digit in the frame was also blank (leading blanking). A blank after a non-blank digit is invalid.
- Undefined: 7'b1111111 is always invalid.

Test Plan:
- Reset, then strobes 0100100(sof), 0110000, 0011001, 0010010 on consecutive cycles, out_ready=1 -> out_valid one cycle after the 4th strobe, bcd_out=16'h2345, bin_out=2345, err=0; out_valid drops the cycle after acceptance.
- Frame 0011000(sof), 0011000, 0011000, 0011000, out_ready=0 for 5 cycles, extra strobe during HOLD -> bcd_out=16'h9999, bin_out=9999 held stable, overrun=1 and stays 1.
- Frame with 3rd digit 1010101 (digits 1, 2, bad, 4) -> bcd_out=16'h12F4, err=1, bin_out=0.
- Two digits 1, 2, then sof with 7, then 8, 9, 0 -> the first partial frame is dropped; result 16'h7890, bin_out=7890.
- resetn=0 after 2 digits, then a complete frame 5, 0, 0, 6 -> bcd_out=16'h5006, bin_out=5006, no residue from the aborted frame.
- SEG7_BLANK_EN defined: 1111111(sof), 1111111, 1111001, 1000000 -> bcd_out=16'h0010, bin_out=10, err=0. Same stimulus with the macro undefined -> err=1, bin_out=0.
